// File: rtl/sddt_stream_monitor.sv
// sddt_stream_monitor: multi-channel AXI-Stream traffic monitor for SDDT debug readback.
// Counts beats, packets and stall cycles per tapped stream, with atomic snapshot,
// clear and wrap/saturate modes, read through two 32-bit GPIO status words.
// Drives the heartbeat LEDs from a free-running counter.
// Optional build macro SDDT_MON_STALL_RUN_EN adds a per-channel longest-stall-run
// tracker readable with cnt_sel=3; without it cnt_sel=3 reads 0.
module sddt_stream_monitor #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32,
  parameter int LED_BIT   = 20
) (
  input  logic              c0_ddr4_clk,
  input  logic              c0_ddr4_rst,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic [NUM_CH-1:0] ch_tlast,
  input  logic [31:0]       ctrl_in,
  output logic [31:0]       status_out,
  output logic [31:0]       status_out2,
  output logic [3:0]        user_led
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Advance a counter on its event; in saturate mode an all-ones counter holds.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cur,
                                                    input logic ev,
                                                    input logic sat);
    if (!ev)
      return cur;
    if (sat && (cur == CNT_MAX))
      return cur;
    return cur + CNT_ONE;
  endfunction

  // Value a live counter takes on a clear edge: the clearing cycle's own event still counts.
  function automatic logic [CNT_WIDTH-1:0] clr_val(input logic ev);
    return ev ? CNT_ONE : '0;
  endfunction

  // Control word fields
  logic [3:0] ch_sel;
  logic [1:0] cnt_sel;
  logic       snap_lvl;
  logic       clr_lvl;
  logic       sat_mode;

  assign ch_sel   = ctrl_in[3:0];
  assign cnt_sel  = ctrl_in[5:4];
  assign snap_lvl = ctrl_in[8];
  assign clr_lvl  = ctrl_in[9];
  assign sat_mode = ctrl_in[10];

  // Per-channel events
  logic [NUM_CH-1:0] beat;
  logic [NUM_CH-1:0] pkt;
  logic [NUM_CH-1:0] stall;

  assign beat  = ch_tvalid & ch_tready;
  assign pkt   = beat & ch_tlast;
  assign stall = ch_tvalid & ~ch_tready;

  // Edge detection and snapshot sequence
  logic       snap_prev_p0;
  logic       clr_prev_p0;
  logic       snap_edge;
  logic       clr_edge;
  logic [7:0] snap_seq_p0;

  assign snap_edge = snap_lvl & ~snap_prev_p0;
  assign clr_edge  = clr_lvl & ~clr_prev_p0;

  // Live counters, overflow flags and shadows
  logic [CNT_WIDTH-1:0] beats_p0  [NUM_CH];
  logic [CNT_WIDTH-1:0] pkts_p0   [NUM_CH];
  logic [CNT_WIDTH-1:0] stalls_p0 [NUM_CH];
  logic [2:0]           ovf_p0    [NUM_CH];
  logic [CNT_WIDTH-1:0] beats_upd  [NUM_CH];
  logic [CNT_WIDTH-1:0] pkts_upd   [NUM_CH];
  logic [CNT_WIDTH-1:0] stalls_upd [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_beats_p1  [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_pkts_p1   [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_stalls_p1 [NUM_CH];

  logic [31:0] heartbeat;

  // Prevent edge triggers from levels already high at reset release; count snapshots.
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      snap_prev_p0 <= 1'b1;
      clr_prev_p0  <= 1'b1;
      snap_seq_p0  <= '0;
    end else begin
      snap_prev_p0 <= snap_lvl;
      clr_prev_p0  <= clr_lvl;
      if (snap_edge)
        snap_seq_p0 <= snap_seq_p0 + 8'd1;
    end
  end

  // Post-update values of this cycle, before any clear; these are also what a snapshot captures.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      beats_upd[c]  = cnt_next(beats_p0[c], beat[c], sat_mode);
      pkts_upd[c]   = cnt_next(pkts_p0[c], pkt[c], sat_mode);
      stalls_upd[c] = cnt_next(stalls_p0[c], stall[c], sat_mode);
    end
  end

  // Live counters, sticky overflow flags and snapshot shadows.
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        beats_p0[c]     <= '0;
        pkts_p0[c]      <= '0;
        stalls_p0[c]    <= '0;
        ovf_p0[c]       <= '0;
        sh_beats_p1[c]  <= '0;
        sh_pkts_p1[c]   <= '0;
        sh_stalls_p1[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_edge) begin
          beats_p0[c]  <= clr_val(beat[c]);
          pkts_p0[c]   <= clr_val(pkt[c]);
          stalls_p0[c] <= clr_val(stall[c]);
          ovf_p0[c]    <= '0;
        end else begin
          beats_p0[c]  <= beats_upd[c];
          pkts_p0[c]   <= pkts_upd[c];
          stalls_p0[c] <= stalls_upd[c];
          ovf_p0[c]    <= ovf_p0[c] | {stall[c] && (stalls_p0[c] == CNT_MAX),
                                       pkt[c]   && (pkts_p0[c]   == CNT_MAX),
                                       beat[c]  && (beats_p0[c]  == CNT_MAX)};
        end
        if (snap_edge) begin
          sh_beats_p1[c]  <= beats_upd[c];
          sh_pkts_p1[c]   <= pkts_upd[c];
          sh_stalls_p1[c] <= stalls_upd[c];
        end
      end
    end
  end

`ifdef SDDT_MON_STALL_RUN_EN
  logic [CNT_WIDTH-1:0] run_p0    [NUM_CH];
  logic [CNT_WIDTH-1:0] max_p0    [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_max_p1 [NUM_CH];
  logic [CNT_WIDTH-1:0] run_upd   [NUM_CH];
  logic [CNT_WIDTH-1:0] max_upd   [NUM_CH];

  // Current stall run (saturating) and the running maximum including this cycle.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      run_upd[c] = stall[c] ? cnt_next(run_p0[c], 1'b1, 1'b1) : '0;
      max_upd[c] = (run_upd[c] > max_p0[c]) ? run_upd[c] : max_p0[c];
    end
  end

  // Track longest stall run; clear zeroes the maximum, snapshot shadows it.
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        run_p0[c]    <= '0;
        max_p0[c]    <= '0;
        sh_max_p1[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        run_p0[c] <= run_upd[c];
        max_p0[c] <= clr_edge ? '0 : max_upd[c];
        if (snap_edge)
          sh_max_p1[c] <= max_upd[c];
      end
    end
  end
`endif

  // Readback selection
  logic [CNT_WIDTH-1:0] sel_cnt;
  logic [2:0]           sel_ovf;

  // Select shadow counter and live flags of ch_sel; out-of-range channels read 0.
  always_comb begin
    sel_cnt = '0;
    sel_ovf = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_sel == 4'(c)) begin
        sel_ovf = ovf_p0[c];
        case (cnt_sel)
          2'd0:    sel_cnt = sh_beats_p1[c];
          2'd1:    sel_cnt = sh_pkts_p1[c];
          2'd2:    sel_cnt = sh_stalls_p1[c];
          default: begin
`ifdef SDDT_MON_STALL_RUN_EN
            sel_cnt = sh_max_p1[c];
`else
            sel_cnt = '0;
`endif
          end
        endcase
      end
    end
  end

  // Register both status words for the GPIO readback.
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      status_out  <= '0;
      status_out2 <= '0;
    end else begin
      status_out  <= 32'(sel_cnt);
      status_out2 <= {15'b0, sat_mode, snap_seq_p0, 5'b0, sel_ovf};
    end
  end

  // Free-running heartbeat for the LEDs.
  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst)
      heartbeat <= '0;
    else
      heartbeat <= heartbeat + 32'd1;
  end

  assign user_led = heartbeat[LED_BIT+3:LED_BIT];

  // Reserved control bits and the heartbeat bits not routed to LEDs.
  logic ctrl_unused;
  assign ctrl_unused = ^{ctrl_in[31:11], ctrl_in[7:6], heartbeat};

endmodule

// File: tb/tb_sddt_stream_monitor.sv
// tb_sddt_stream_monitor: directed self-checking bench for sddt_stream_monitor.
// Built with CNT_WIDTH=8 so wrap/saturate is reachable, LED_BIT=2 so the heartbeat
// is visible on user_led within a short run.
module tb_sddt_stream_monitor;

  localparam int NUM_CH    = 4;
  localparam int CNT_WIDTH = 8;
  localparam int LED_BIT   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] tvalid;
  logic [NUM_CH-1:0] tready;
  logic [NUM_CH-1:0] tlast;
  logic [31:0]       ctrl;
  logic [31:0]       status_out;
  logic [31:0]       status_out2;
  logic [3:0]        user_led;

  int n_tests = 0;
  int n_fail  = 0;

  sddt_stream_monitor #(
    .NUM_CH   (NUM_CH),
    .CNT_WIDTH(CNT_WIDTH),
    .LED_BIT  (LED_BIT)
  ) dut (
    .c0_ddr4_clk(clk),
    .c0_ddr4_rst(rst),
    .ch_tvalid  (tvalid),
    .ch_tready  (tready),
    .ch_tlast   (tlast),
    .ctrl_in    (ctrl),
    .status_out (status_out),
    .status_out2(status_out2),
    .user_led   (user_led)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    tvalid = '0;
    tready = '0;
    tlast  = '0;
    ctrl   = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic traffic_off();
    tvalid = '0;
    tready = '0;
    tlast  = '0;
  endtask

  task automatic snap();
    ctrl[8] = 1'b1;
    step(1);
    ctrl[8] = 1'b0;
  endtask

  task automatic sel(input int ch, input int cs);
    ctrl[3:0] = ch[3:0];
    ctrl[5:4] = cs[1:0];
    step(1);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    ctrl   = 32'h0000_0300;
    tvalid = '1;
    tready = '1;
    tlast  = '0;
    step(3);
    n_tests++;
    if (status_out !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_status_out got %0h expected 0", status_out);
    end
    n_tests++;
    if (status_out2 !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_status_out2 got %0h expected 0", status_out2);
    end
    n_tests++;
    if (user_led !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_led got %0h expected 0", user_led);
    end
    rst = 1'b0;
    step(20);
    n_tests++;
    if (user_led !== 4'd5) begin
      n_fail++;
      $display("FAIL heartbeat_led got %0d expected 5", user_led);
    end
    n_tests++;
    if (status_out2[15:8] !== 8'd0) begin
      n_fail++;
      $display("FAIL held_snap_seq got %0d expected 0", status_out2[15:8]);
    end
    n_tests++;
    if (status_out !== 32'd0) begin
      n_fail++;
      $display("FAIL held_snap_shadow got %0d expected 0", status_out);
    end
    traffic_off();
    ctrl = '0;
    step(1);
  endtask

  task automatic test_beats();
    do_reset();
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tlast[0] = (i == 5) || (i == 10);
      step(1);
    end
    traffic_off();
    snap();
    sel(0, 0);
    n_tests++;
    if (status_out !== 32'd10) begin
      n_fail++;
      $display("FAIL ch0_beats got %0d expected 10", status_out);
    end
    n_tests++;
    if (status_out2[15:8] !== 8'd1) begin
      n_fail++;
      $display("FAIL ch0_snap_seq got %0d expected 1", status_out2[15:8]);
    end
    sel(0, 1);
    n_tests++;
    if (status_out !== 32'd2) begin
      n_fail++;
      $display("FAIL ch0_pkts got %0d expected 2", status_out);
    end
    sel(0, 2);
    n_tests++;
    if (status_out !== 32'd0) begin
      n_fail++;
      $display("FAIL ch0_stalls got %0d expected 0", status_out);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_run;
    do_reset();
    tvalid[1] = 1'b1;
    tready[1] = 1'b0;
    step(7);
    tready[1] = 1'b1;
    step(1);
    traffic_off();
    snap();
    sel(1, 2);
    n_tests++;
    if (status_out !== 32'd7) begin
      n_fail++;
      $display("FAIL ch1_stalls got %0d expected 7", status_out);
    end
    sel(1, 0);
    n_tests++;
    if (status_out !== 32'd1) begin
      n_fail++;
      $display("FAIL ch1_beats got %0d expected 1", status_out);
    end
`ifdef SDDT_MON_STALL_RUN_EN
    exp_run = 32'd7;
`else
    exp_run = 32'd0;
`endif
    sel(1, 3);
    n_tests++;
    if (status_out !== exp_run) begin
      n_fail++;
      $display("FAIL ch1_max_run got %0d expected %0d", status_out, exp_run);
    end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    tvalid[2] = 1'b1;
    tready[2] = 1'b1;
    step(260);
    traffic_off();
    snap();
    sel(2, 0);
    n_tests++;
    if (status_out !== 32'd4) begin
      n_fail++;
      $display("FAIL wrap_beats got %0d expected 4", status_out);
    end
    n_tests++;
    if (status_out2[2:0] !== 3'b001) begin
      n_fail++;
      $display("FAIL wrap_ovf got %b expected 001", status_out2[2:0]);
    end
    ctrl[9] = 1'b1;
    step(1);
    ctrl[9] = 1'b0;
    step(1);
    n_tests++;
    if (status_out2[2:0] !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_ovf got %b expected 000", status_out2[2:0]);
    end
    ctrl[10]  = 1'b1;
    tvalid[2] = 1'b1;
    tready[2] = 1'b1;
    step(260);
    traffic_off();
    snap();
    sel(2, 0);
    n_tests++;
    if (status_out !== 32'd255) begin
      n_fail++;
      $display("FAIL sat_beats got %0d expected 255", status_out);
    end
    n_tests++;
    if (status_out2[2:0] !== 3'b001) begin
      n_fail++;
      $display("FAIL sat_ovf got %b expected 001", status_out2[2:0]);
    end
    n_tests++;
    if (status_out2[16] !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_echo got %b expected 1", status_out2[16]);
    end
  endtask

  task automatic test_out_of_range();
    sel(6, 0);
    n_tests++;
    if (status_out !== 32'd0) begin
      n_fail++;
      $display("FAIL oor6_status got %0d expected 0", status_out);
    end
    n_tests++;
    if (status_out2[2:0] !== 3'b000) begin
      n_fail++;
      $display("FAIL oor6_ovf got %b expected 000", status_out2[2:0]);
    end
    sel(5, 2);
    n_tests++;
    if (status_out !== 32'd0) begin
      n_fail++;
      $display("FAIL oor5_status got %0d expected 0", status_out);
    end
    ctrl[10] = 1'b0;
  endtask

  task automatic test_snap_clr();
    do_reset();
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    step(5);
    ctrl[8] = 1'b1;
    ctrl[9] = 1'b1;
    step(1);
    ctrl[8] = 1'b0;
    ctrl[9] = 1'b0;
    traffic_off();
    sel(0, 0);
    n_tests++;
    if (status_out !== 32'd6) begin
      n_fail++;
      $display("FAIL snapclr_shadow got %0d expected 6", status_out);
    end
    snap();
    sel(0, 0);
    n_tests++;
    if (status_out !== 32'd1) begin
      n_fail++;
      $display("FAIL snapclr_live got %0d expected 1", status_out);
    end
    n_tests++;
    if (status_out2[15:8] !== 8'd2) begin
      n_fail++;
      $display("FAIL snapclr_seq got %0d expected 2", status_out2[15:8]);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    step(100);
    traffic_off();
    snap();
    sel(0, 0);
    n_tests++;
    if (status_out !== 32'd100) begin
      n_fail++;
      $display("FAIL pre_rst_beats got %0d expected 100", status_out);
    end
    ctrl[10]  = 1'b1;
    tvalid[0] = 1'b1;
    tready[0] = 1'b1;
    tlast[0]  = 1'b1;
    step(1);
    rst = 1'b1;
    step(1);
    n_tests++;
    if (status_out !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_status_out got %0h expected 0", status_out);
    end
    n_tests++;
    if (status_out2 !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_status_out2 got %0h expected 0", status_out2);
    end
    n_tests++;
    if (user_led !== 4'd0) begin
      n_fail++;
      $display("FAIL midrst_led got %0h expected 0", user_led);
    end
    rst = 1'b0;
    step(3);
    traffic_off();
    snap();
    sel(0, 0);
    n_tests++;
    if (status_out !== 32'd3) begin
      n_fail++;
      $display("FAIL post_rst_beats got %0d expected 3", status_out);
    end
    sel(0, 1);
    n_tests++;
    if (status_out !== 32'd3) begin
      n_fail++;
      $display("FAIL post_rst_pkts got %0d expected 3", status_out);
    end
    ctrl = '0;
  endtask

  initial begin
    rst    = 1'b1;
    tvalid = '0;
    tready = '0;
    tlast  = '0;
    ctrl   = '0;
    test_reset();
    test_beats();
    test_stall();
    test_wrap_sat();
    test_out_of_range();
    test_snap_clr();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
